// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// Module     : branch_pkg
// Description: Shared constants for the branch sequencer. Holds the branch
//              opcode values, the FSM state encoding and the reset value of
//              the predictor's 2-bit counters.
// Revision   : 1.0 - initial release
// ============================================================================
package branch_pkg;

  localparam logic [5:0] OP_BEQ = 6'b001110;
  localparam logic [5:0] OP_BNE = 6'b001111;
  localparam logic [5:0] OP_J   = 6'b010000;
  localparam logic [5:0] OP_BLT = 6'b010001;

  // Weakly not-taken
  localparam logic [1:0] CNT_RESET = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RESOLVE = 2'd1,
    S_UPDATE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/branch_bht.sv
`default_nettype none
// ============================================================================
// Module     : branch_bht
// Description: Branch history table of 2-bit saturating counters.
//              Combinational read port, single synchronous update port,
//              asynchronous active-low reset of every counter to CNT_RESET.
// Ports      : clk, rst_n            - clock / async active-low reset
//              rd_idx  -> rd_cnt     - read port
//              upd_en, upd_idx,
//              upd_taken             - increment (taken) / decrement counter
// Revision   : 1.0 - initial release
// ============================================================================
module branch_bht
  import branch_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_cnt,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  logic [1:0] cnt [DEPTH];

  assign rd_cnt = cnt[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        cnt[i] <= CNT_RESET;
      end
    end else if (upd_en) begin
      if (upd_taken && (cnt[upd_idx] != 2'b11)) begin
        cnt[upd_idx] <= cnt[upd_idx] + 2'b01;
      end else if (!upd_taken && (cnt[upd_idx] != 2'b00)) begin
        cnt[upd_idx] <= cnt[upd_idx] - 2'b01;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_seq.sv
`default_nettype none
// ============================================================================
// Module     : branch_seq
// Description: Single-issue branch sequencer. Accepts one instruction in
//              IDLE, resolves it in RESOLVE, commits pc / taken in UPDATE.
//              Optional 2-bit predictor enabled by macro BRANCH_PRED_EN.
// Ports      : clk, rst_n                 - clock / async active-low reset
//              instr_valid, instr_ready   - instruction handshake
//              instruction, rs_val, rt_val- instruction and operand values
//              stall                      - holds the UPDATE state
//              pc                         - program counter
//              taken, mispredict          - one-cycle resolution pulses
// Revision   : 1.0 - initial release
// ============================================================================
module branch_seq
  import branch_pkg::*;
#(
  parameter int PC_W      = 9,
  parameter int BHT_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instruction,
  input  logic [31:0]     rs_val,
  input  logic [31:0]     rt_val,
  input  logic            stall,
  output logic [PC_W-1:0] pc,
  output logic            taken,
  output logic            mispredict
);

  state_t state, state_nxt;

  logic            accept;
  logic            leave_update;
  logic [5:0]      op_q;
  logic [15:0]     imm_q;
  logic [31:0]     rs_q, rt_q;
  logic [PC_W-1:0] pc_br;

  logic            is_cond, outcome;
  logic [31:0]     imm_sx, imm_zx, rel_sum;
  logic [PC_W-1:0] target;

  logic            res_taken, res_cond;
  logic [PC_W-1:0] res_target;
  logic            unused_ok;

  assign accept       = instr_valid && instr_ready;
  assign leave_update = (state == S_UPDATE) && !stall;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = S_RESOLVE;
      end
      S_RESOLVE: state_nxt = S_UPDATE;
      S_UPDATE:  if (!stall) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------------ capture stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      imm_q <= '0;
      rs_q  <= '0;
      rt_q  <= '0;
      pc_br <= '0;
    end else if (accept) begin
      op_q  <= instruction[31:26];
      imm_q <= instruction[15:0];
      rs_q  <= rs_val;
      rt_q  <= rt_val;
      pc_br <= pc;
    end
  end

  // ------------------------------------------------------ resolve logic
  assign imm_sx  = {{16{imm_q[15]}}, imm_q};
  assign imm_zx  = {16'd0, imm_q};
  // Computed at 32 bits; only the low PC_W bits matter (wrap modulo 2^PC_W)
  assign rel_sum = {{(32-PC_W){1'b0}}, pc_br} + 32'd1 + imm_sx;

  always_comb begin
    is_cond = 1'b0;
    outcome = 1'b0;
    target  = rel_sum[PC_W-1:0];
    case (op_q)
      OP_BEQ: begin is_cond = 1'b1; outcome = (rs_q == rt_q); end
      OP_BNE: begin is_cond = 1'b1; outcome = (rs_q != rt_q); end
      OP_BLT: begin is_cond = 1'b1; outcome = ($signed(rs_q) < $signed(rt_q)); end
      OP_J:   begin outcome = 1'b1; target = imm_zx[PC_W-1:0]; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_taken  <= 1'b0;
      res_cond   <= 1'b0;
      res_target <= '0;
    end else if (state == S_RESOLVE) begin
      res_taken  <= outcome;
      res_cond   <= is_cond;
      res_target <= target;
    end
  end

  // ------------------------------------------------------- commit stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= '0;
      taken <= 1'b0;
    end else begin
      taken <= 1'b0;
      if (leave_update) begin
        pc    <= res_taken ? res_target : pc_br + PC_W'(1);
        taken <= res_taken;
      end
    end
  end

  // Register-field bits and the discarded high sum bits have no function here
  assign unused_ok = ^{instruction[25:16], rel_sum[31:PC_W], imm_zx[31:PC_W]};

  // ---------------------------------------------------------- predictor
`ifdef BRANCH_PRED_EN
  localparam int IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

  logic [1:0] bht_cnt;
  logic       res_pred;
  logic       mis_q;
  logic       unused_pred;

  branch_bht #(
    .DEPTH (BHT_DEPTH),
    .IDX_W (IDX_W)
  ) u_bht (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (pc_br[IDX_W-1:0]),
    .rd_cnt    (bht_cnt),
    .upd_en    (leave_update && res_cond),
    .upd_idx   (pc_br[IDX_W-1:0]),
    .upd_taken (res_taken)
  );

  assign unused_pred = bht_cnt[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_pred <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      if (state == S_RESOLVE) res_pred <= bht_cnt[1];
      mis_q <= leave_update && res_cond && (res_pred != res_taken);
    end
  end

  assign mispredict = mis_q;
`else
  assign mispredict = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_seq.sv
`default_nettype none
// ============================================================================
// Module     : tb_branch_seq
// Description: Self-checking bench for branch_seq. A behavioural model
//              predicts pc / taken / mispredict for every issued
//              instruction; expectations are queued at issue and compared
//              when the sequencer returns to IDLE.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_branch_seq;

  localparam logic [5:0] BEQ = 6'b001110;
  localparam logic [5:0] BNE = 6'b001111;
  localparam logic [5:0] JMP = 6'b010000;
  localparam logic [5:0] BLT = 6'b010001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instruction = '0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        stall = 1'b0;
  logic [8:0]  pc;
  logic        taken;
  logic        mispredict;

  typedef struct {
    logic [8:0] pc;
    logic       tk;
    logic       mp;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   m_pc = 0;
  int   m_cnt[16];

  branch_seq #(.PC_W(9), .BHT_DEPTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instruction (instruction),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .stall       (stall),
    .pc          (pc),
    .taken       (taken),
    .mispredict  (mispredict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0;
    for (int i = 0; i < 16; i++) m_cnt[i] = 1;
  endtask

  // Reset applied at a negedge; outputs must clear without a clock edge
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_pc", pc, 0);
    chk("rst_ready", instr_ready, 1);
    chk("rst_taken", taken, 0);
    chk("rst_mispredict", mispredict, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] imm, input int stall_n);
    exp_t e;
    logic [8:0] pc_before;
    bit   cond, tk, done;
    int   tgt, simm, idx, edges;
    pc_before = m_pc[8:0];
    simm = int'($signed(imm));
    cond = (op == BEQ) || (op == BNE) || (op == BLT);
    case (op)
      BEQ:     tk = (a == b);
      BNE:     tk = (a != b);
      BLT:     tk = ($signed(a) < $signed(b));
      JMP:     tk = 1'b1;
      default: tk = 1'b0;
    endcase
    tgt = (op == JMP) ? (int'(imm) & 511) : ((m_pc + 1 + simm) & 511);
    idx = m_pc & 15;
    e.mp = 1'b0;
`ifdef BRANCH_PRED_EN
    if (cond) e.mp = ((m_cnt[idx] >= 2) != tk);
`endif
    if (cond) begin
      if (tk && m_cnt[idx] < 3) m_cnt[idx]++;
      else if (!tk && m_cnt[idx] > 0) m_cnt[idx]--;
    end
    m_pc = tk ? tgt : ((m_pc + 1) & 511);
    e.pc = m_pc[8:0];
    e.tk = tk;
    sb.push_back(e);

    @(negedge clk);
    chk("ready_idle", instr_ready, 1);
    instr_valid = 1'b1;
    instruction = {op, 10'd0, imm};
    rs_val = a;
    rt_val = b;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    chk("ready_busy", instr_ready, 0);
    if (stall_n > 0) stall = 1'b1;
    done  = 1'b0;
    edges = 99;
    for (int k = 1; k <= 20 && !done; k++) begin
      @(negedge clk);
      if (instr_ready) begin
        done  = 1'b1;
        edges = 1 + k;
      end else if (k >= 2 && k <= stall_n + 1) begin
        chk("stall_pc_hold", pc, pc_before);
        chk("stall_taken_low", taken, 0);
      end
      if (k == stall_n + 1) stall = 1'b0;
    end
    stall = 1'b0;
    chk("latency_edges", edges, 3 + stall_n);
    e = sb.pop_front();
    chk("pc", pc, e.pc);
    chk("taken", taken, e.tk);
    chk("mispredict", mispredict, e.mp);
    @(negedge clk);
    chk("taken_pulse_end", taken, 0);
    chk("mispredict_pulse_end", mispredict, 0);
  endtask

  initial begin
    logic [5:0] ops [6];
    ops[0] = BEQ; ops[1] = BNE; ops[2] = JMP; ops[3] = BLT; ops[4] = 6'h00; ops[5] = 6'h3F;
    model_reset();

    // Reset state
    do_reset();
    chk("idle_pc", pc, 0);
    chk("idle_ready", instr_ready, 1);

    // Taken BEQ forward
    issue(BEQ, 32'd5, 32'd5, 16'h001C, 0);
    chk("beq_pc29", pc, 29);

    // BNE not-taken then BLT signed taken
    do_reset();
    issue(BNE, 32'd7, 32'd7, 16'h0010, 0);
    issue(BLT, 32'hFFFF_FFFF, 32'd0, 16'h0000, 0);

    // Absolute jump to top, wrap, negative relative wrap
    issue(JMP, 32'd0, 32'd0, 16'h01FF, 0);
    issue(6'b000001, 32'd0, 32'd0, 16'h0000, 0);
    issue(BEQ, 32'd3, 32'd3, 16'hFFFE, 0);

    // Three stall cycles in UPDATE
    issue(BNE, 32'd1, 32'd2, 16'h0003, 3);

    // Reset while in RESOLVE discards the instruction
    @(negedge clk);
    instr_valid = 1'b1;
    instruction = {BEQ, 10'd0, 16'h0040};
    rs_val = 32'd9;
    rt_val = 32'd9;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_pc", pc, 0);
    chk("midrst_ready", instr_ready, 1);
    chk("midrst_taken", taken, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    chk("postrst_pc", pc, 0);
    chk("postrst_taken", taken, 0);

    // Predictor training at pc=4
    issue(JMP, 32'd0, 32'd0, 16'h0004, 0);
    issue(BEQ, 32'd1, 32'd1, 16'hFFFF, 0);
    issue(BEQ, 32'd1, 32'd1, 16'hFFFF, 0);
    issue(BEQ, 32'd1, 32'd2, 16'hFFFF, 0);

    // Random mix
    for (int i = 0; i < 10; i++) begin
      issue(ops[$urandom_range(0, 5)], 32'($urandom_range(0, 3)) - 32'd1,
            32'($urandom_range(0, 3)) - 32'd1, 16'($urandom), (i % 3 == 0) ? 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
